seq_cb_multiplier: RTL and testbench
====================================

Name: seq_cb_multiplier

Overview:
- Sequential, parametrised successor to the combinational column-bypass array multiplier.
- Processes one multiplier bit per cycle with shift-add. The accumulator adder is gated off for zero multiplier bits, which is the bypass.
- Optionally terminates early once the remaining multiplier bits are all zero.
- Sits behind valid/ready handshakes so it can be dropped into pipelined datapaths. It also reports an adder-activation count for low-power characterisation.

Parameters:
M, 4, multiplicand (a) width, >=2
N, 4, multiplier (x) width, >=2
EARLY_TERM, 1, 1 = stop after highest set bit of x; 0 = always run N bit-cycles
BYPASS, 1, 1 = hold accumulator (no adder enable) on zero multiplier bits; 0 = add zero every cycle
CW, $clog2(N+1), width of the cycle and activation counters

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operands valid
in_ready  out  1  block can accept operands
a  in  M  multiplicand, unsigned
x  in  N  multiplier, unsigned
out_valid  out  1  product valid
out_ready  in  1  consumer accepts product
p  out  M+N  product a*x, unsigned
run_cycles  out  CW  bit-cycles spent on this product
add_count  out  CW  accumulator adder activations for this product

Behaviour:
- Reset (async, rst_n=0):
  - State is IDLE.
  - in_ready=1; out_valid=0; p=0; run_cycles=0; add_count=0.
  - All internal registers are cleared.
  - Reset mid-operation aborts the product; no out_valid is produced for it.
- States:
  - IDLE: in_ready=1.
  - RUN: in_ready=0.
  - DONE: out_valid=1, in_ready=0.
- IDLE -> RUN on in_valid&in_ready at a clock edge:
  - Register a and x.
  - Clear acc, bit index k, run_cycles and add_count.
  - in_valid while not in IDLE is ignored; the source must hold it.
- RUN, each cycle processes bit k:
  - If x[k]=1: acc <= acc + (a << k) and add_count increments.
  - If x[k]=0 and BYPASS=1: acc register enable is low (acc unchanged, adder operands gated).
  - If x[k]=0 and BYPASS=0: acc <= acc + 0; add_count does not increment.
  - run_cycles increments every RUN cycle; k increments.
- RUN -> DONE after processing bit k when either condition holds:
  - k==N-1.
  - EARLY_TERM=1 and x[N-1:k+1]==0.
  - On this transition p <= final acc.
- Cycle counts:
  - Minimum RUN length is 1 cycle, including x=0.
  - With EARLY_TERM=1: RUN length = max(1, msb_index(x)+1).
  - With EARLY_TERM=0: RUN length = N.
- DONE:
  - p, run_cycles and add_count are held stable while out_ready=0.
  - On out_ready=1: DONE -> IDLE. out_valid deasserts the next cycle; p retains its value until the next DONE.
- Latency: acceptance edge T → out_valid high from edge T+L, where L = RUN length. Next acceptance is possible at the earliest one cycle after the product handshake.
- Arithmetic:
  - acc is M+N bits; no overflow is possible.
  - The shifted addend is zero-extended.
  - All operands are unsigned.
- Boundaries:
  - a=0: adds still occur per set x bit, product is 0.
  - x all ones: L=N, add_count=N.
  - Maximum values a=2^M-1, x=2^N-1 give p=(2^M-1)(2^N-1).
  - add_count can never exceed run_cycles.

Decomposition:
- Shared package (cb_mult_pkg):
  - State enum (IDLE, RUN, DONE).
  - Counter-width helper function.
  - EARLY_TERM/BYPASS mode constants, shared with the combinational multiplier family.
- Natural sub-module: cb_remaining_zero_detect, an N-bit "x[N-1:k+1]==0" detector indexed by k, used for early termination.
- The datapath (acc, gated adder) and FSM stay in the top module.

Test Plan:
- Full operands: M=N=4, defaults, a=15, x=15 -> p=225, run_cycles=4, add_count=4, out_valid 4 cycles after accept.
- Sparse multiplier: a=14, x=15 -> p=210. Then a=13, x=1 -> p=13, run_cycles=1, add_count=1 (early termination). Then a=7, x=8 -> p=56, run_cycles=4, add_count=1, acc register enable low for 3 cycles (BYPASS).
- Zero multiplier: a=11, x=0 -> p=0, run_cycles=1, add_count=0. With EARLY_TERM=0: a=11, x=1 -> p=11, run_cycles=4.
- Backpressure: a=11, x=7 with out_ready low for 5 cycles -> p=77 stable, out_valid held, in_ready=0; in_valid pulses are ignored until the handshake completes.
- Reset mid-RUN: start a=15, x=15, drop rst_n at cycle 2 -> immediately in_ready=1, out_valid=0, p=0. A new a=3, x=5 after release -> p=15.
- Randomised sweep at M=8, N=6, both modes -> p==a*x for every product and add_count==popcount(x).

Source files
------------

// File: rtl/cb_mult_pkg.sv
// Shared definitions for the column-bypass multiplier family.
// Holds FSM state encodings, mode constants and a counter-width helper.
// No logic; imported by every block of the family.
package cb_mult_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // Mode selections shared with the combinational variants
  localparam int ET_OFF     = 0;
  localparam int ET_ON      = 1;
  localparam int BYPASS_OFF = 0;
  localparam int BYPASS_ON  = 1;

  // Width that can hold a count from 0 up to n inclusive
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/cb_remaining_zero_detect.sv
// Flags when every multiplier bit above index k is zero.
// Purely combinational, zero latency.
// No handshake; evaluated every cycle from the registered operand.
module cb_remaining_zero_detect #(
  parameter int N  = 4,
  parameter int KW = 2
) (
  input  logic [N-1:0]  x,
  input  logic [KW-1:0] k,
  output logic          rem_zero
);

  // Scan the bits strictly above k; any set bit means work remains
  always_comb begin
    rem_zero = 1'b1;
    for (int i = 0; i < N; i++) begin
      if ((i > int'(k)) && x[i]) rem_zero = 1'b0;
    end
  end

endmodule

// File: rtl/seq_cb_multiplier.sv
// Shift-add unsigned multiplier, one multiplier bit per cycle, adder gated on zero bits.
// Latency: 1..N cycles from accept to out_valid (N when early termination is off).
// Backpressure: product, run_cycles and add_count hold in DONE until out_ready.
module seq_cb_multiplier
  import cb_mult_pkg::*;
#(
  parameter int M          = 4,
  parameter int N          = 4,
  parameter int EARLY_TERM = ET_ON,
  parameter int BYPASS     = BYPASS_ON,
  parameter int CW         = cnt_width(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [M-1:0]   a,
  input  logic [N-1:0]   x,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [M+N-1:0] p,
  output logic [CW-1:0]  run_cycles,
  output logic [CW-1:0]  add_count
);

  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = M + N;

  state_t        state;
  logic [M-1:0]  a_r;
  logic [N-1:0]  x_r;
  logic [PW-1:0] acc;
  logic [PW-1:0] p_r;
  logic [KW-1:0] k;
  logic [CW-1:0] rc_r;
  logic [CW-1:0] ac_r;

  logic          bit_set;
  logic          acc_en;
  logic          rem_zero;
  logic          last_bit;
  logic [PW-1:0] addend;
  logic [PW-1:0] acc_sum;

  cb_remaining_zero_detect #(
    .N  (N),
    .KW (KW)
  ) u_rzd (
    .x        (x_r),
    .k        (k),
    .rem_zero (rem_zero)
  );

  // Bit-k datapath: addend is forced to zero unless the bit is set, so the adder sees no toggles
  always_comb begin
    bit_set  = x_r[k];
    acc_en   = (BYPASS == BYPASS_ON) ? bit_set : 1'b1;
    addend   = bit_set ? (PW'(a_r) << k) : '0;
    acc_sum  = acc + addend;
    last_bit = (k == KW'(N - 1)) || ((EARLY_TERM == ET_ON) && rem_zero);
  end

  // Control FSM plus accumulator, bit index and characterisation counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      a_r   <= '0;
      x_r   <= '0;
      acc   <= '0;
      p_r   <= '0;
      k     <= '0;
      rc_r  <= '0;
      ac_r  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_r   <= a;
            x_r   <= x;
            acc   <= '0;
            k     <= '0;
            rc_r  <= '0;
            ac_r  <= '0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          rc_r <= rc_r + CW'(1);
          k    <= k + KW'(1);
          if (acc_en)  acc  <= acc_sum;
          if (bit_set) ac_r <= ac_r + CW'(1);
          if (last_bit) begin
            p_r   <= acc_sum;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready   = (state == ST_IDLE);
  assign out_valid  = (state == ST_DONE);
  assign p          = p_r;
  assign run_cycles = rc_r;
  assign add_count  = ac_r;

endmodule

// File: tb/tb_seq_cb_multiplier.sv
module tb_seq_cb_multiplier;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // 4x4 default configuration
  logic       in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
  logic [3:0] a4 = '0, x4 = '0;
  logic [7:0] p;
  logic [2:0] rc, ac;

  // 4x4 with early termination disabled
  logic       iv_e0 = 1'b0, e0_ir, e0_ov, e0_or = 1'b1;
  logic [7:0] e0_p;
  logic [2:0] e0_rc, e0_ac;

  // 8x6 pair: defaults and (no early term, no bypass), shared inputs
  logic        w_iv = 1'b0, w_or = 1'b1;
  logic [7:0]  a8 = '0;
  logic [5:0]  x6 = '0;
  logic        w1_ir, w1_ov, w0_ir, w0_ov;
  logic [13:0] w1_p, w0_p;
  logic [2:0]  w1_rc, w1_ac, w0_rc, w0_ac;

  seq_cb_multiplier #(.M(4), .N(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a4), .x(x4),
    .out_valid(out_valid), .out_ready(out_ready), .p(p), .run_cycles(rc), .add_count(ac));

  seq_cb_multiplier #(.M(4), .N(4), .EARLY_TERM(0)) u_e0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_e0), .in_ready(e0_ir), .a(a4), .x(x4),
    .out_valid(e0_ov), .out_ready(e0_or), .p(e0_p), .run_cycles(e0_rc), .add_count(e0_ac));

  seq_cb_multiplier #(.M(8), .N(6)) u_w1 (
    .clk(clk), .rst_n(rst_n), .in_valid(w_iv), .in_ready(w1_ir), .a(a8), .x(x6),
    .out_valid(w1_ov), .out_ready(w_or), .p(w1_p), .run_cycles(w1_rc), .add_count(w1_ac));

  seq_cb_multiplier #(.M(8), .N(6), .EARLY_TERM(0), .BYPASS(0)) u_w0 (
    .clk(clk), .rst_n(rst_n), .in_valid(w_iv), .in_ready(w0_ir), .a(a8), .x(x6),
    .out_valid(w0_ov), .out_ready(w_or), .p(w0_p), .run_cycles(w0_rc), .add_count(w0_ac));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One transaction on the default instance; out_ready held low for 'stall' cycles after out_valid
  task automatic do_mul(input logic [3:0] ta, input logic [3:0] tx, input int stall,
                        output logic [7:0] tp, output logic [2:0] trc, output logic [2:0] tac,
                        output int tlat, output int ten_low);
    @(negedge clk);
    a4 = ta; x4 = tx; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    tlat = 0; ten_low = 0;
    while (!out_valid && tlat < 20) begin
      if (!u_dut.acc_en) ten_low++;
      @(posedge clk);
      #1 tlat++;
    end
    chk("out_valid_rise", 32'(out_valid), 32'd1);
    tp = p; trc = rc; tac = ac;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      in_valid = i[0];
      a4 = 4'd2; x4 = 4'd3;
      @(posedge clk);
      #1;
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_p", 32'(p), 32'(tp));
      chk("stall_run_cycles", 32'(rc), 32'(trc));
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("post_hs_out_valid", 32'(out_valid), 32'd0);
    chk("post_hs_in_ready", 32'(in_ready), 32'd1);
    chk("post_hs_p_retained", 32'(p), 32'(tp));
  endtask

  initial begin
    logic [7:0] rp;
    logic [2:0] rrc, rac;
    int lat, enl;
    logic [7:0] ra;
    logic [5:0] rx;
    int exp_rc1;
    bit got1, got0;
    int cyc;

    // Reset values
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_p", 32'(p), 32'd0);
    chk("rst_run_cycles", 32'(rc), 32'd0);
    chk("rst_add_count", 32'(ac), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Full operands
    do_mul(4'd15, 4'd15, 0, rp, rrc, rac, lat, enl);
    chk("full_p", 32'(rp), 32'd225);
    chk("full_rc", 32'(rrc), 32'd4);
    chk("full_ac", 32'(rac), 32'd4);
    chk("full_lat", 32'(lat), 32'd4);

    // Sparse multipliers
    do_mul(4'd14, 4'd15, 0, rp, rrc, rac, lat, enl);
    chk("a14x15_p", 32'(rp), 32'd210);
    do_mul(4'd13, 4'd1, 0, rp, rrc, rac, lat, enl);
    chk("a13x1_p", 32'(rp), 32'd13);
    chk("a13x1_rc", 32'(rrc), 32'd1);
    chk("a13x1_ac", 32'(rac), 32'd1);
    chk("a13x1_lat", 32'(lat), 32'd1);
    do_mul(4'd7, 4'd8, 0, rp, rrc, rac, lat, enl);
    chk("a7x8_p", 32'(rp), 32'd56);
    chk("a7x8_rc", 32'(rrc), 32'd4);
    chk("a7x8_ac", 32'(rac), 32'd1);
    chk("a7x8_en_low", 32'(enl), 32'd3);

    // Zero multiplier
    do_mul(4'd11, 4'd0, 0, rp, rrc, rac, lat, enl);
    chk("x0_p", 32'(rp), 32'd0);
    chk("x0_rc", 32'(rrc), 32'd1);
    chk("x0_ac", 32'(rac), 32'd0);
    chk("x0_lat", 32'(lat), 32'd1);

    // a=0 still produces zero with adds per set bit
    do_mul(4'd0, 4'd5, 0, rp, rrc, rac, lat, enl);
    chk("a0_p", 32'(rp), 32'd0);
    chk("a0_ac", 32'(rac), 32'd2);

    // Early termination disabled: full N cycles even for x=1
    @(negedge clk);
    a4 = 4'd11; x4 = 4'd1; iv_e0 = 1'b1;
    @(posedge clk);
    #1 iv_e0 = 1'b0;
    cyc = 0;
    while (!e0_ov && cyc < 20) begin
      @(posedge clk);
      #1 cyc++;
    end
    chk("et0_out_valid", 32'(e0_ov), 32'd1);
    chk("et0_p", 32'(e0_p), 32'd11);
    chk("et0_rc", 32'(e0_rc), 32'd4);
    chk("et0_ac", 32'(e0_ac), 32'd1);
    chk("et0_lat", 32'(cyc), 32'd4);

    // Backpressure with ignored in_valid pulses
    do_mul(4'd11, 4'd7, 5, rp, rrc, rac, lat, enl);
    chk("bp_p", 32'(rp), 32'd77);
    chk("bp_rc", 32'(rrc), 32'd3);
    chk("bp_ac", 32'(rac), 32'd3);

    // Reset in the middle of RUN
    @(negedge clk);
    a4 = 4'd15; x4 = 4'd15; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_p", 32'(p), 32'd0);
    chk("midrst_rc", 32'(rc), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_mul(4'd3, 4'd5, 0, rp, rrc, rac, lat, enl);
    chk("after_rst_p", 32'(rp), 32'd15);
    chk("after_rst_rc", 32'(rrc), 32'd3);
    chk("after_rst_ac", 32'(rac), 32'd2);

    // Randomised 8x6 sweep in both modes
    for (int it = 0; it < 40; it++) begin
      if (it == 0) begin ra = 8'd255; rx = 6'd63; end
      else if (it == 1) begin ra = 8'd200; rx = 6'd0; end
      else begin ra = 8'($urandom_range(0, 255)); rx = 6'($urandom_range(0, 63)); end
      exp_rc1 = 1;
      for (int j = 0; j < 6; j++) if (rx[j]) exp_rc1 = j + 1;
      @(posedge clk);
      @(negedge clk);
      a8 = ra; x6 = rx; w_iv = 1'b1;
      @(posedge clk);
      #1 w_iv = 1'b0;
      got1 = 1'b0; got0 = 1'b0; cyc = 0;
      while (!(got1 && got0) && cyc < 20) begin
        if (w1_ov && !got1) begin
          got1 = 1'b1;
          chk("sw_et1_p", 32'(w1_p), 32'(ra) * 32'(rx));
          chk("sw_et1_ac", 32'(w1_ac), 32'($countones(rx)));
          chk("sw_et1_rc", 32'(w1_rc), 32'(exp_rc1));
        end
        if (w0_ov && !got0) begin
          got0 = 1'b1;
          chk("sw_et0_p", 32'(w0_p), 32'(ra) * 32'(rx));
          chk("sw_et0_ac", 32'(w0_ac), 32'($countones(rx)));
          chk("sw_et0_rc", 32'(w0_rc), 32'd6);
        end
        if (!(got1 && got0)) begin
          @(posedge clk);
          #1 cyc++;
        end
      end
      chk("sw_both_done", 32'(got1 && got0), 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
